// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fir_pkg                                                        |
// | Shared definitions for the fir_filter / fir_inverse family: default      |
// | coefficient set and its array type, accumulator width helper and the     |
// | deconvolution FSM state encoding.                                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package fir_pkg;

  localparam int DEF_N   = 3;
  localparam int DEF_W_K = 4;

  // Coefficient array at the default order/width; entry i is K[i], signed.
  typedef logic [DEF_N:0][DEF_W_K-1:0] coef_arr_t;

  localparam coef_arr_t K_DEFAULT = {4'd1, 4'd1, 4'd1, 4'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Wide enough that y minus every tap product can never wrap.
  function automatic int w_acc(input int w_x, input int w_k, input int n, input int w_y);
    int prod_sum;
    prod_sum = w_x + w_k + $clog2(n + 1);
    return ((w_y > prod_sum) ? w_y : prod_sum) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_inverse_sat_trunc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sat_trunc                                                      |
// | Combinational signed saturator, W_IN -> W_OUT (W_IN >= W_OUT).           |
// | Ports   : in_val  [W_IN]  signed input                                   |
// |           out_val [W_OUT] input clamped to the W_OUT signed range        |
// |           ovf             high when clamping took place                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sat_trunc #(
  parameter int W_IN  = 13,
  parameter int W_OUT = 4
) (
  input  logic signed [W_IN-1:0]  in_val,
  output logic signed [W_OUT-1:0] out_val,
  output logic                    ovf
);

  // The value fits iff every bit from the output sign bit upward is identical.
  logic [W_IN-W_OUT:0] top_bits;
  assign top_bits = in_val[W_IN-1:W_OUT-1];

  always_comb begin
    ovf     = !((&top_bits) || !(|top_bits));
    out_val = in_val[W_OUT-1:0];
    if (ovf) begin
      out_val = in_val[W_IN-1] ? {1'b1, {(W_OUT-1){1'b0}}}
                               : {1'b0, {(W_OUT-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_inverse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fir_inverse                                                    |
// | Recovers x from y = sum K[i]*x[n-i] (K[0]=1) by the recursion            |
// | x[n] = y[n] - sum_{i=1..N} K[i]*x[n-i], one tap per cycle through one    |
// | shared multiplier. Recovered samples are saturated to W_X bits.          |
// | Ports   : clk, rstn (async, active-low), clr (sync history clear)        |
// |           s_valid/s_ready/s_y   : input FIR sample stream                |
// |           m_valid/m_ready/m_x/m_ovf : recovered sample stream            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fir_inverse
  import fir_pkg::*;
#(
  parameter int                     N   = DEF_N,
  parameter int                     W_X = 4,
  parameter int                     W_K = DEF_W_K,
  parameter int                     W_Y = W_X + W_K + N + 1,
  parameter logic [N:0][W_K-1:0]    K   = K_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [W_Y-1:0] s_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [W_X-1:0] m_x,
  output logic                  m_ovf
);

  localparam int W_ACC = w_acc(W_X, W_K, N, W_Y);
  localparam int HN    = (N > 0) ? N : 1;       // keep arrays legal for N=0
  localparam int TW    = $clog2(N + 2);         // tap counts 1..N+1

  if (K[0] != W_K'(1)) begin : g_k0_check
    $error("fir_inverse: K[0] must equal 1");
  end

  fir_state_e             state_q, state_d;
  logic signed [W_X-1:0]  hist_q [HN];
  logic signed [W_X-1:0]  hist_d [HN];
  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic [TW-1:0]          tap_q, tap_d;
  logic                   m_valid_q, m_valid_d;
  logic signed [W_X-1:0]  m_x_q, m_x_d;
  logic                   m_ovf_q, m_ovf_d;

  logic signed [W_K-1:0]     k_sel;
  logic signed [W_X-1:0]     h_sel;
  logic signed [W_K+W_X-1:0] prod;
  logic signed [W_ACC-1:0]   sat_in;
  logic signed [W_X-1:0]     sat_x;
  logic                      sat_ovf;

  // Tap operand select: tap i pairs K[i] with hist[i-1].
  always_comb begin
    k_sel = '0;
    h_sel = '0;
    for (int i = 1; i <= N; i++) begin
      if (tap_q == TW'(i)) begin
        k_sel = K[i];
        h_sel = hist_q[i-1];
      end
    end
    prod = (W_K+W_X)'(k_sel) * (W_K+W_X)'(h_sel);
  end

  // With no taps the incoming sample goes straight to the output register.
  assign sat_in = (N == 0) ? W_ACC'(s_y) : acc_q;

  sat_trunc #(
    .W_IN  (W_ACC),
    .W_OUT (W_X)
  ) u_sat (
    .in_val  (sat_in),
    .out_val (sat_x),
    .ovf     (sat_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    hist_d    = hist_q;
    m_valid_d = m_valid_q;
    m_x_d     = m_x_q;
    m_ovf_d   = m_ovf_q;

    case (state_q)
      IDLE: begin
        // A coincident handshake sees the cleared history, which is what
        // hist_q holds by the time the first tap is evaluated.
        if (clr) begin
          for (int i = 0; i < HN; i++) hist_d[i] = '0;
        end
        if (s_valid) begin
          acc_d = W_ACC'(s_y);
          if (N == 0) begin
            state_d   = OUT;
            m_valid_d = 1'b1;
            m_x_d     = sat_x;
            m_ovf_d   = sat_ovf;
          end else begin
            tap_d   = TW'(1);
            state_d = MAC;
          end
        end
      end

      MAC: begin
        if (clr) begin
          for (int i = 0; i < HN; i++) hist_d[i] = '0;
          state_d = IDLE;
        end else if (tap_q <= TW'(N)) begin
          acc_d = acc_q - W_ACC'(prod);
          tap_d = tap_q + TW'(1);
        end else begin
          // All taps applied: emit and push the emitted (saturated) value.
          state_d   = OUT;
          m_valid_d = 1'b1;
          m_x_d     = sat_x;
          m_ovf_d   = sat_ovf;
          hist_d[0] = sat_x;
          for (int i = 1; i < HN; i++) hist_d[i] = hist_q[i-1];
        end
      end

      OUT: begin
        if (clr) begin
          for (int i = 0; i < HN; i++) hist_d[i] = '0;
        end
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      tap_q     <= '0;
      m_valid_q <= 1'b0;
      m_x_q     <= '0;
      m_ovf_q   <= 1'b0;
      for (int i = 0; i < HN; i++) hist_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      m_valid_q <= m_valid_d;
      m_x_q     <= m_x_d;
      m_ovf_q   <= m_ovf_d;
      for (int i = 0; i < HN; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign s_ready = (state_q == IDLE);
  assign m_valid = m_valid_q;
  assign m_x     = m_x_q;
  assign m_ovf   = m_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_inverse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fir_inverse                                                 |
// | Self-checking bench for fir_inverse with the default N=3, K={1,1,1,1}.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fir_inverse;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clr;
  logic              s_valid;
  logic              s_ready;
  logic signed [11:0] s_y;
  logic              m_valid;
  logic              m_ready;
  logic signed [3:0] m_x;
  logic              m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int kk [4] = '{1, 1, 1, 1};

  typedef struct {
    int y;
    bit c;    // clr asserted together with the handshake
    int ex;
    int eo;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  fir_inverse dut (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_y     (s_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x     (m_x),
    .m_ovf   (m_ovf)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Handshake one sample (m_ready assumed high), expect output 4 cycles later.
  task automatic send_check(input int y, input bit c, input int ex, input int eo,
                            input string nm);
    int w;
    int lat;
    w = 0;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({nm, "_rdy"}, int'(s_ready), 1);
    s_valid = 1'b1;
    s_y     = 12'(y);
    clr     = c;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    clr     = 1'b0;
    lat = 0;
    while (!m_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_x"}, int'(m_x), ex);
    check({nm, "_ovf"}, int'(m_ovf), eo);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    int w;
    int xh [3];
    int x;
    int y;
    bit got;

    tbl[0] = '{1,   1'b0,  1, 0};
    tbl[1] = '{3,   1'b0,  2, 0};
    tbl[2] = '{6,   1'b0,  3, 0};
    tbl[3] = '{5,   1'b0, -1, 0};
    tbl[4] = '{20,  1'b1,  7, 1};
    tbl[5] = '{-20, 1'b1, -8, 1};
    tbl[6] = '{-1,  1'b0,  7, 0};

    rstn = 1'b0; clr = 1'b0; s_valid = 1'b0; s_y = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mvalid", int'(m_valid), 0);
    check("rst_sready", int'(s_ready), 1);
    check("rst_mx", int'(m_x), 0);
    check("rst_movf", int'(m_ovf), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_check(tbl[i].y, tbl[i].c, tbl[i].ex, tbl[i].eo, $sformatf("tbl%0d", i));
    end

    // clr during MAC: build history {3,2,1}, then abort a sample.
    send_check(1, 1'b1, 1, 0, "pre0");
    send_check(3, 1'b0, 2, 0, "pre1");
    send_check(6, 1'b0, 3, 0, "pre2");
    s_valid = 1'b1; s_y = 12'sd9;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    repeat (8) begin
      if (m_valid) seen = 1;
      @(negedge clk);
    end
    check("abort_noout", seen, 0);
    check("abort_sready", int'(s_ready), 1);
    send_check(5, 1'b0, 5, 0, "after_abort");

    // Async reset in the middle of MAC (history {5,0,0} is discarded).
    s_valid = 1'b1; s_y = 12'sd7;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_mvalid", int'(m_valid), 0);
    check("midrst_sready", int'(s_ready), 1);
    rstn = 1'b1;
    @(negedge clk);
    send_check(2, 1'b0, 2, 0, "after_rst");

    // Backpressure: history {2,0,0}, y=4 -> x=2; a second sample is offered
    // throughout and must not be taken.
    m_ready = 1'b0;
    s_valid = 1'b1; s_y = 12'sd4;
    @(posedge clk);
    @(negedge clk);
    s_y = 12'sd100;
    w = 0;
    while (!m_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("bp_lat", w, 4);
    repeat (5) begin
      @(negedge clk);
      check("bp_mvalid", int'(m_valid), 1);
      check("bp_mx", int'(m_x), 2);
      check("bp_movf", int'(m_ovf), 0);
      check("bp_sready", int'(s_ready), 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_mvalid", int'(m_valid), 0);
    check("bp_rel_sready", int'(s_ready), 1);
    send_check(2, 1'b0, -2, 0, "bp_next");

    // Random loopback through a behavioural fir_filter model.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) xh[k] = 0;
    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(15, 0)) - 8;
      y = kk[0] * x + kk[1] * xh[0] + kk[2] * xh[1] + kk[3] * xh[2];
      xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = x;
      w = 0;
      while (!s_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("rnd_rdy", int'(s_ready), 1);
      s_valid = 1'b1;
      s_y = 12'(y);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        m_ready = 1'($urandom_range(1, 0));
        if (m_valid && m_ready) begin
          check($sformatf("rnd_x%0d", n), m_ovf ? 100 : int'(m_x), x);
          got = 1'b1;
        end
        @(negedge clk);
      end
      if (!got) check($sformatf("rnd_timeout%0d", n), 0, 1);
    end
    m_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
